// File: rtl/gcd_pkg.sv
// ----------------------------------------------------------------------------
// gcd_pkg
// Shared types for the GCD operand feeder and its FIFO.
//   GCD_DATA_W     : default operand width
//   feeder_state_e : feeder FSM states
//   gcd_pair_t     : one {a, b} operand pair at the default width
//   sat_inc16      : 16-bit saturating increment, used by the statistics counters
// ----------------------------------------------------------------------------
package gcd_pkg;

    localparam int GCD_DATA_W = 32;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_ISSUE,
        FS_WAIT,
        FS_BYP
    } feeder_state_e;

    typedef struct packed {
        logic [GCD_DATA_W-1:0] a;
        logic [GCD_DATA_W-1:0] b;
    } gcd_pair_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/gcd_pair_fifo.sv
// ----------------------------------------------------------------------------
// gcd_pair_fifo
// Synchronous show-ahead FIFO of operand pairs. The head entry is visible on
// pop_data whenever empty=0; pop consumes it on the rising edge.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write an entry (ignored while full)
//   pop, pop_data     : consume the head entry (ignored while empty)
//   full, empty       : occupancy flags
//   count             : number of stored entries (clog2(DEPTH)+1 bits)
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module gcd_pair_fifo
    import gcd_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type pair_t = gcd_pair_t,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  pair_t            push_data,
    input  logic             pop,
    output pair_t            pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    pair_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign pop_data = mem[rd_ptr_reg];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/gcd_operand_feeder.sv
// ----------------------------------------------------------------------------
// gcd_operand_feeder
// Upstream stage of the subtractive GCD core. Buffers operand pairs in a FIFO,
// issues them one at a time to the core and waits for core_done. Pairs with a
// zero operand are resolved here (the core would never terminate on them) and
// reported on the bypass port, in input order with the core results.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : input handshake, in_a/in_b operands
//   core_start             : one-cycle pulse, core samples core_a/core_b
//   core_a, core_b         : registered operands, stable until core_done
//   core_done              : core finished the current pair
//   byp_valid, byp_gcd     : one-cycle pulse with a locally resolved GCD
//   busy                   : FIFO non-empty or FSM not idle
//   issue_cnt, byp_cnt     : saturating event counters, only present when
//                            GCD_FEEDER_STATS_EN is defined
// ----------------------------------------------------------------------------
module gcd_operand_feeder
    import gcd_pkg::*;
#(
    parameter int DATA_W = GCD_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              core_start,
    output logic [DATA_W-1:0] core_a,
    output logic [DATA_W-1:0] core_b,
    input  logic              core_done,
    output logic              byp_valid,
    output logic [DATA_W-1:0] byp_gcd,
    output logic              busy
`ifdef GCD_FEEDER_STATS_EN
    ,
    output logic [15:0]       issue_cnt,
    output logic [15:0]       byp_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Same layout as gcd_pair_t, but following the DATA_W parameter.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } pair_t;

    feeder_state_e     state_reg;
    feeder_state_e     state_next;
    logic [DATA_W-1:0] hold_a_reg;
    logic [DATA_W-1:0] hold_b_reg;

    pair_t             push_pair;
    pair_t             head_pair;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              head_has_zero;

    assign push_pair.a = in_a;
    assign push_pair.b = in_b;
    // in_ready depends on full only, so a same-cycle pop never opens a full FIFO.
    assign in_ready    = !fifo_full;
    assign fifo_push   = in_valid && in_ready;

    gcd_pair_fifo #(
        .DEPTH  (DEPTH),
        .pair_t (pair_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_pair),
        .pop       (fifo_pop),
        .pop_data  (head_pair),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_has_zero = (head_pair.a == '0) || (head_pair.b == '0);

    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            FS_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = head_has_zero ? FS_BYP : FS_ISSUE;
                end
            end
            FS_ISSUE: state_next = FS_WAIT;
            FS_WAIT: begin
                // core_done only matters here; elsewhere it is ignored.
                if (core_done) begin
                    state_next = FS_IDLE;
                end
            end
            FS_BYP:   state_next = FS_IDLE;
            default:  state_next = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= FS_IDLE;
            hold_a_reg <= '0;
            hold_b_reg <= '0;
        end else begin
            state_reg <= state_next;
            // Hold registers only change on a pop, so they stay stable through
            // ISSUE/WAIT and keep the last pair while idle.
            if (fifo_pop) begin
                hold_a_reg <= head_pair.a;
                hold_b_reg <= head_pair.b;
            end
        end
    end

    assign core_start = (state_reg == FS_ISSUE);
    assign core_a     = hold_a_reg;
    assign core_b     = hold_b_reg;
    assign byp_valid  = (state_reg == FS_BYP);
    // At least one operand is zero in BYP, so the OR is the other operand
    // (gcd(x,0)=x, gcd(0,0)=0).
    assign byp_gcd    = byp_valid ? (hold_a_reg | hold_b_reg) : '0;
    assign busy       = (fifo_count != '0) || (state_reg != FS_IDLE);

`ifdef GCD_FEEDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            byp_cnt   <= '0;
        end else begin
            if (core_start) begin
                issue_cnt <= sat_inc16(issue_cnt);
            end
            if (byp_valid) begin
                byp_cnt <= sat_inc16(byp_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_gcd_operand_feeder.sv
module tb_gcd_operand_feeder;
    import gcd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        core_start;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_done;
    logic        byp_valid;
    logic [31:0] byp_gcd;
    logic        busy;
`ifdef GCD_FEEDER_STATS_EN
    logic [15:0] issue_cnt;
    logic [15:0] byp_cnt;
`endif

    always #5 clk = ~clk;

    gcd_operand_feeder #(
        .DATA_W (32),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .core_start (core_start),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_done  (core_done),
        .byp_valid  (byp_valid),
        .byp_gcd    (byp_gcd),
        .busy       (busy)
`ifdef GCD_FEEDER_STATS_EN
        ,
        .issue_cnt  (issue_cnt),
        .byp_cnt    (byp_cnt)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: accepted pairs in order, plus the core's outstanding job.
    gcd_pair_t   exp_q[$];
    bit          outstanding  = 0;
    bit          issue_cycle  = 0;
    int          cd           = 0;
    int          lat_min      = 1;
    int          lat_max      = 4;
    bit          auto_core    = 1;
    bit          manual_done  = 0;
    bit          spurious_en  = 0;
    logic [31:0] held_a;
    logic [31:0] held_b;
    int          n_issue      = 0;
    int          n_byp        = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          byp;
        logic [31:0] gcd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic bit has_zero(input gcd_pair_t p);
        return (p.a == 0) || (p.b == 0);
    endfunction

    function automatic logic [31:0] zero_gcd(input gcd_pair_t p);
        return (p.a == 0) ? p.b : p.a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        gcd_pair_t p;
        if (core_start) begin
            check("start_while_outstanding", outstanding, 0);
            check("start_with_byp", byp_valid, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_start", 1, 0);
            end else begin
                p = exp_q.pop_front();
                check("issue_kind", has_zero(p), 0);
                check("core_a", core_a, p.a);
                check("core_b", core_b, p.b);
                n_issue++;
            end
            outstanding = 1;
            issue_cycle = 1;
            cd          = $urandom_range(lat_max, lat_min);
            held_a      = core_a;
            held_b      = core_b;
        end else if (outstanding) begin
            check("core_a_hold", core_a, held_a);
            check("core_b_hold", core_b, held_b);
        end
        if (byp_valid && !core_start) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byp", 1, 0);
            end else begin
                p = exp_q.pop_front();
                check("byp_kind", has_zero(p), 1);
                check("byp_gcd", byp_gcd, zero_gcd(p));
                n_byp++;
            end
        end
    endtask

    // One clock cycle: drive inputs, model the core, then observe outputs.
    task automatic step(input bit offer, input logic [31:0] a, input logic [31:0] b);
        gcd_pair_t p;
        in_valid  = offer;
        in_a      = a;
        in_b      = b;
        core_done = 0;
        if (outstanding && issue_cycle) begin
            // done here lands on the ISSUE cycle and must be ignored
            issue_cycle = 0;
            if (spurious_en && $urandom_range(0, 1) == 0) core_done = 1;
        end else if (outstanding && auto_core) begin
            if (cd <= 1) begin
                core_done   = 1;
                outstanding = 0;
            end else begin
                cd--;
            end
        end else if (outstanding && manual_done) begin
            core_done   = 1;
            outstanding = 0;
            manual_done = 0;
        end else if (!outstanding && spurious_en && $urandom_range(0, 5) == 0) begin
            core_done = 1;
        end
        if (offer && in_ready) begin
            p.a = a;
            p.b = b;
            exp_q.push_back(p);
        end
        tick();
        in_valid  = 0;
        core_done = 0;
        observe();
    endtask

    task automatic drain(input int limit);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || outstanding || busy) && g < limit) begin
            step(0, 0, 0);
            g++;
        end
        check("drain_timeout", (g < limit), 1);
        check("drain_busy", busy, 0);
        check("drain_in_ready", in_ready, 1);
    endtask

    initial begin
        vec_t vecs[8];
        int   base_issue;
        int   base_byp;
        int   tries;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{a: 32'd48,         b: 32'd18,         byp: 0, gcd: 32'd0};
        vecs[1] = '{a: 32'd0,          b: 32'd21,         byp: 1, gcd: 32'd21};
        vecs[2] = '{a: 32'd0,          b: 32'd0,          byp: 1, gcd: 32'd0};
        vecs[3] = '{a: 32'd35,         b: 32'd0,          byp: 1, gcd: 32'd35};
        vecs[4] = '{a: 32'd1,          b: 32'd1,          byp: 0, gcd: 32'd0};
        vecs[5] = '{a: 32'hFFFF_FFFF,  b: 32'd0,          byp: 1, gcd: 32'hFFFF_FFFF};
        vecs[6] = '{a: 32'd0,          b: 32'h8000_0000,  byp: 1, gcd: 32'h8000_0000};
        vecs[7] = '{a: 32'hDEAD_BEEF,  b: 32'h1234_5678,  byp: 0, gcd: 32'd0};

        rst_n     = 0;
        in_valid  = 0;
        in_a      = 0;
        in_b      = 0;
        core_done = 0;
        #1;
        repeat (3) tick();
        check("rst_core_start", core_start, 0);
        check("rst_core_a", core_a, 0);
        check("rst_core_b", core_b, 0);
        check("rst_byp_valid", byp_valid, 0);
        check("rst_byp_gcd", byp_gcd, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1;
        tick();

        // Table: single pair into an idle feeder, latency and hold checks.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1;
            in_a     = vecs[i].a;
            in_b     = vecs[i].b;
            tick();
            in_valid = 0;
            check("lat1_start", core_start, 0);
            check("lat1_byp", byp_valid, 0);
            check("lat1_busy", busy, 1);
            tick();
            check("lat2_start", core_start, !vecs[i].byp);
            check("lat2_byp", byp_valid, vecs[i].byp);
            if (vecs[i].byp) begin
                check("tbl_byp_gcd", byp_gcd, vecs[i].gcd);
                tick();
                check("tbl_byp_pulse", byp_valid, 0);
                check("tbl_byp_busy", busy, 0);
            end else begin
                check("tbl_core_a", core_a, vecs[i].a);
                check("tbl_core_b", core_b, vecs[i].b);
                for (int k = 0; k < 4; k++) begin
                    tick();
                    check("tbl_start_pulse", core_start, 0);
                    check("tbl_hold_a", core_a, vecs[i].a);
                    check("tbl_hold_b", core_b, vecs[i].b);
                    check("tbl_wait_busy", busy, 1);
                end
                core_done = 1;
                tick();
                core_done = 0;
                check("tbl_done_busy", busy, 0);
                check("tbl_idle_a", core_a, vecs[i].a);
            end
            $display("vector %0d a=%0h b=%0h byp=%0d", i, vecs[i].a, vecs[i].b, vecs[i].byp);
        end

        // Two zero pairs back to back: bypass only, in order.
        auto_core  = 1;
        base_issue = n_issue;
        base_byp   = n_byp;
        step(1, 0, 21);
        step(1, 0, 0);
        drain(50);
        check("zero_no_issue", n_issue - base_issue, 0);
        check("zero_byp_count", n_byp - base_byp, 2);
        $display("zero pairs: byp=%0d", n_byp - base_byp);

        // Interleave core and bypass work, core takes 3 cycles.
        lat_min    = 3;
        lat_max    = 3;
        base_issue = n_issue;
        base_byp   = n_byp;
        step(1, 12, 8);
        step(1, 0, 7);
        step(1, 9, 6);
        drain(100);
        check("ilv_issue_count", n_issue - base_issue, 2);
        check("ilv_byp_count", n_byp - base_byp, 1);
        $display("interleave: issue=%0d byp=%0d", n_issue - base_issue, n_byp - base_byp);

        // Hold the core and fill the FIFO.
        auto_core  = 0;
        base_issue = n_issue;
        for (int i = 0; i < 5; i++) begin
            tries = 0;
            while (!in_ready && tries < 20) begin
                step(0, 0, 0);
                tries++;
            end
            check("fill_accept", in_ready, 1);
            step(1, 100 + i, 3 + i);
        end
        check("full_in_ready", in_ready, 0);
        check("full_busy", busy, 1);
        step(1, 77, 11);
        check("full_stall_ready", in_ready, 0);
        check("full_queue_len", exp_q.size(), 4);
        check("full_one_issue", n_issue - base_issue, 1);
        manual_done = 1;
        step(1, 77, 11);
        step(1, 77, 11);
        check("after_done_ready", in_ready, 1);
        check("stalled_not_taken", exp_q.size(), 3);
        auto_core = 1;
        lat_min   = 1;
        lat_max   = 4;
        step(1, 77, 11);
        drain(200);
        check("full_total_issue", n_issue - base_issue, 6);
        $display("full test: issued=%0d", n_issue - base_issue);

        // Randomised traffic with spurious done pulses.
        spurious_en = 1;
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            step($urandom_range(0, 1) == 1, ra, rb);
        end
        drain(500);
        spurious_en = 0;
        $display("random: issue=%0d byp=%0d", n_issue, n_byp);

        // Reset in the middle of a WAIT with two pairs queued.
        auto_core = 0;
        step(1, 40, 30);
        step(1, 50, 20);
        step(1, 60, 10);
        check("mid_queue_len", exp_q.size(), 2);
        rst_n = 0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_core_a", core_a, 0);
        exp_q.delete();
        outstanding = 0;
        issue_cycle = 0;
        manual_done = 0;
        n_issue     = 0;
        n_byp       = 0;
        tick();
        rst_n     = 1;
        core_done = 1;
        tick();
        core_done = 0;
        for (int k = 0; k < 4; k++) begin
            check("post_rst_start", core_start, 0);
            check("post_rst_byp", byp_valid, 0);
            check("post_rst_busy", busy, 0);
            check("post_rst_ready", in_ready, 1);
            tick();
        end
        $display("reset mid-operation done");

        // Three core pairs and two zero pairs after a fresh reset.
        auto_core = 1;
        step(1, 3, 5);
        step(1, 0, 4);
        step(1, 7, 7);
        step(1, 0, 0);
        step(1, 10, 4);
        drain(100);
        check("stats_model_issue", n_issue, 3);
        check("stats_model_byp", n_byp, 2);
`ifdef GCD_FEEDER_STATS_EN
        check("issue_cnt", issue_cnt, 3);
        check("byp_cnt", byp_cnt, 2);
`endif
        $display("final sequence: issue=%0d byp=%0d", n_issue, n_byp);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gcd_operand_feeder.md
Name: gcd_operand_feeder

Overview:
- Upstream stage of the GCD core: accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Issues one pair at a time to the core and waits for the core's done before issuing the next.
- Resolves zero-operand pairs locally, since the subtractive core never terminates when exactly one operand is 0. Result order always matches input order.

Parameters:
- DATA_W, 32, operand/result width in bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  producer has a pair on in_a/in_b
- in_ready  output  1  feeder can accept a pair
- in_a  input  DATA_W  operand a
- in_b  input  DATA_W  operand b
- core_start  output  1  one-cycle pulse: core samples core_a/core_b
- core_a  output  DATA_W  operand a to core
- core_b  output  DATA_W  operand b to core
- core_done  input  1  core finished current pair
- byp_valid  output  1  one-cycle pulse: locally resolved result on byp_gcd
- byp_gcd  output  DATA_W  locally resolved GCD
- busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n.
  - Reset clears FIFO pointers and count, sets FSM to IDLE, and clears the hold registers.
  - Output reset values: core_start=0, core_a=0, core_b=0, byp_valid=0, byp_gcd=0, busy=0, in_ready=1.
- Input handshake:
  - in_ready = !full. A push happens on the rising edge when in_valid && in_ready.
  - There is no combinational pass-through: a pair pushed at edge t is poppable from t+1.
  - When full, in_ready=0 even if a pop occurs the same cycle.
- FIFO count width is clog2(DEPTH)+1; pointers wrap modulo DEPTH. Simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, ISSUE, WAIT, BYP.
  - IDLE: if FIFO non-empty, pop the head into hold regs (core_a/core_b). If either operand is 0, go to BYP; otherwise go to ISSUE. If empty, stay.
  - ISSUE: core_start=1 for exactly this cycle; go to WAIT.
  - WAIT: hold core_a/core_b stable; on core_done=1 go to IDLE.
  - BYP: byp_valid=1 and byp_gcd = hold_a | hold_b, which gives gcd(x,0)=x and gcd(0,0)=0; go to IDLE.
- core_a/core_b are registered and stable from ISSUE through the done cycle. They retain their last value in IDLE.
- core_done is ignored in IDLE, ISSUE and BYP; it does not trigger a spurious advance.
- Latency:
  - Pair pushed at edge t into an empty FIFO with FSM in IDLE: core_start is high in cycle t+2.
  - Zero pair pushed at edge t: byp_valid is high in cycle t+2.
- Back-to-back throughput: the next pop occurs in the cycle after done or after BYP.
- Reset mid-operation: all queued pairs are dropped; the in-flight core result is not tracked. A core_done that arrives after reset while in IDLE is ignored.
- busy = (count != 0) || (state != IDLE).

Optional Feature:
- Macro GCD_FEEDER_STATS_EN.
- Defined: adds output ports issue_cnt[15:0] and byp_cnt[15:0].
  - issue_cnt increments on each core_start; byp_cnt increments on each byp_valid.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- gcd_pkg holds:
  - GCD_DATA_W = 32
  - typedef enum logic [1:0] feeder_state_e {FS_IDLE, FS_ISSUE, FS_WAIT, FS_BYP}
  - typedef struct packed gcd_pair_t {a, b}
- Sub-module gcd_pair_fifo: a synchronous FIFO of gcd_pair_t with DEPTH parameter, push/pop/full/empty/count. The feeder instantiates one.

Test Plan:
- Reset, then push (48,18); core model returns done 5 cycles after start -> core_start high exactly 2 cycles after push with core_a=48, core_b=18 held until done; busy drops the cycle after done.
- Push (0,21), then (0,0) -> byp_valid pulses with byp_gcd=21, then 0; core_start never asserted.
- Hold the core (no done) and push 5 pairs (DEPTH=4) -> first pair is issued; FIFO then holds 4 more pairs (full) so in_ready=0 and later pushes stall; after done, in_ready=1 within 1 cycle.
- Interleave (12,8), (0,7), (9,6) with the core taking 3 cycles each -> observed sequence is core_start(12,8), done, byp 7, core_start(9,6); order preserved.
- Assert rst_n=0 mid-WAIT with 2 pairs queued, release, then pulse core_done -> no core_start, no byp_valid, busy=0, in_ready=1.
- With GCD_FEEDER_STATS_EN, run 3 core pairs and 2 zero pairs -> issue_cnt=3, byp_cnt=2.
